xbox_xlr_mvmul: RTL and testbench

//  XBOX accelerator: signed int matrix-vector multiply over XBOX TCM memories.

---
 rtl/xbox_xlr_mvmul.sv | 177 +++++++++++++++++
 tb/tb_xbox_xlr_mvmul.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbox_xlr_mvmul.sv
// Signed int8/int16 matrix-vector multiply over XBOX TCM memories.
// A rows are read from MEM0, vector B from MEM1, and one dot product per row is written to MEM2.
module xbox_xlr_mvmul #(
  parameter int NUM_MEMS           = 3,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int ACC_W              = 32,
  parameter int GO_REG             = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
  output logic [NUM_MEMS*256-1:0]                xlr_mem_wdata,
  output logic [NUM_MEMS*32-1:0]                 xlr_mem_be,
  output logic [NUM_MEMS-1:0]                    xlr_mem_rd,
  output logic [NUM_MEMS-1:0]                    xlr_mem_wr,
  input  logic [NUM_MEMS*256-1:0]                xlr_mem_rdata,
  input  logic [32*32-1:0]                       host_regs,
  input  logic [31:0]                            host_regs_valid_pulse,
  output logic [32*32-1:0]                       host_regs_data_out,
  output logic [31:0]                            host_regs_valid_out
);

  localparam int AW = LOG2_LINES_PER_MEM;
  localparam int LW = AW + 1;
  localparam int RW = AW + 4;
  localparam logic [63:0] LINES = 64'(1) << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAST,
    S_WB,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic            go;
  logic [31:0]     csr_l, csr_r;
  logic            bad_cfg;
  logic [LW-1:0]   len_q, line_q, a_idx_q;
  logic [RW-1:0]   rows_q, row_q;
  logic            mode_q, rd_q, done_q, err_q;
  logic [31:0]     cyc_q;
  logic [ACC_W-1:0] acc_q, lane_sum;
  logic            last_line, last_row, busy;
  logic [255:0]    a_line, b_line;
  logic signed [15:0] a8, b8, p8;
  logic signed [31:0] a16, b16, p16;
  logic            unused_bits;

  assign go        = host_regs_valid_pulse[GO_REG] & (|host_regs[32*GO_REG +: 32]);
  assign csr_l     = host_regs[32*2 +: 32];
  assign csr_r     = host_regs[32*3 +: 32];
  assign bad_cfg   = (csr_l == 32'd0) || (csr_r == 32'd0) ||
                     ((64'(csr_r) * 64'(csr_l)) > LINES) ||
                     (64'(csr_l) > LINES) || (64'(csr_r) > (LINES << 3));
  assign last_line = (line_q == len_q - 1'b1);
  assign last_row  = (row_q == rows_q - 1'b1);
  assign busy      = (state == S_RD) || (state == S_LAST) || (state == S_WB);
  assign a_line    = xlr_mem_rdata[0 +: 256];
  assign b_line    = xlr_mem_rdata[256 +: 256];

  assign host_regs_data_out  = {{30{32'b0}}, cyc_q, 29'b0, err_q, busy, done_q};
  assign host_regs_valid_out = 32'h0000_0003;

  assign unused_bits = ^{host_regs, host_regs_valid_pulse, csr_l, csr_r,
                         xlr_mem_rdata[NUM_MEMS*256-1:512], a_idx_q[LW-1]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    xlr_mem_addr  = '0;
    xlr_mem_wdata = '0;
    xlr_mem_be    = '0;
    xlr_mem_rd    = '0;
    xlr_mem_wr    = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (go) state_nxt = bad_cfg ? S_DONE : S_RD;
      end
      S_RD: begin
        xlr_mem_rd[0]          = 1'b1;
        xlr_mem_rd[1]          = 1'b1;
        xlr_mem_addr[0 +: AW]  = a_idx_q[AW-1:0];
        xlr_mem_addr[AW +: AW] = line_q[AW-1:0];
        xlr_mem_be[0 +: 32]    = '1;
        xlr_mem_be[32 +: 32]   = '1;
        if (last_line) state_nxt = S_LAST;
      end
      S_LAST: state_nxt = S_WB;
      S_WB: begin
        xlr_mem_wr[2]            = 1'b1;
        xlr_mem_addr[2*AW +: AW] = AW'(row_q >> 3);
        xlr_mem_be[64 +: 32]     = 32'hF << {row_q[2:0], 2'b00};
        for (int w = 0; w < 8; w++) begin
          if (row_q[2:0] == 3'(w)) xlr_mem_wdata[512 + 32*w +: ACC_W] = acc_q;
        end
        state_nxt = last_row ? S_DONE : S_RD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane products are sign-extended to ACC_W before summing so the total wraps mod 2^ACC_W.
  always_comb begin
    lane_sum = '0;
    a8 = '0; b8 = '0; p8 = '0;
    a16 = '0; b16 = '0; p16 = '0;
    for (int i = 0; i < 32; i++) begin
      a8 = 16'($signed(a_line[8*i +: 8]));
      b8 = 16'($signed(b_line[8*i +: 8]));
      p8 = a8 * b8;
      if (!mode_q) lane_sum = lane_sum + ACC_W'(p8);
    end
    for (int i = 0; i < 16; i++) begin
      a16 = 32'($signed(a_line[16*i +: 16]));
      b16 = 32'($signed(b_line[16*i +: 16]));
      p16 = a16 * b16;
      if (mode_q) lane_sum = lane_sum + ACC_W'(p16);
    end
  end

  // rd_q marks the cycle in which the line read last cycle is on xlr_mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      rows_q  <= '0;
      line_q  <= '0;
      row_q   <= '0;
      a_idx_q <= '0;
      mode_q  <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      acc_q   <= '0;
    end else begin
      rd_q <= (state == S_RD);
      if (rd_q) acc_q <= acc_q + lane_sum;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            len_q   <= csr_l[LW-1:0];
            rows_q  <= csr_r[RW-1:0];
            mode_q  <= host_regs[32*4];
            done_q  <= bad_cfg;
            err_q   <= bad_cfg;
            cyc_q   <= '0;
            line_q  <= '0;
            row_q   <= '0;
            a_idx_q <= '0;
            acc_q   <= '0;
          end
        end
        S_RD: begin
          line_q  <= last_line ? '0 : line_q + 1'b1;
          a_idx_q <= a_idx_q + 1'b1;
          cyc_q   <= cyc_q + 1'b1;
        end
        S_LAST: cyc_q <= cyc_q + 1'b1;
        S_WB: begin
          cyc_q <= cyc_q + 1'b1;
          acc_q <= '0;
          row_q <= row_q + 1'b1;
          if (last_row) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbox_xlr_mvmul.sv
// Self-checking bench for xbox_xlr_mvmul: behavioural TCM memories, a dot-product
// reference model, a table of directed vectors, random runs and multi-cycle corner sequences.
module tb_xbox_xlr_mvmul;

  localparam int NM = 3;
  localparam int AW = 8;
  localparam int LINES = 256;

  logic clk = 1'b0;
  logic rst;
  logic [NM*AW-1:0]  addr;
  logic [NM*256-1:0] wdata;
  logic [NM*256-1:0] rdata;
  logic [NM*32-1:0]  be;
  logic [NM-1:0]     rd, wr;
  logic [1023:0]     hostRegs;
  logic [31:0]       hostPulse;
  logic [1023:0]     dataOut;
  logic [31:0]       validOut;

  int checks = 0;
  int failures = 0;

  logic [255:0] mem0 [LINES];
  logic [255:0] mem1 [LINES];
  logic [255:0] mem2 [LINES];
  logic [255:0] exp2 [LINES];
  bit mem2Init = 1'b0;
  int rdCnt [3] = '{0, 0, 0};
  int wrCnt [3] = '{0, 0, 0};
  int rdBase [3];
  int wrBase [3];

  typedef struct {
    string       name;
    bit          mode;
    int          lenL;
    int          rowsR;
    int          pat;
    logic [15:0] aval;
    logic [15:0] bval;
    bit          expErr;
    bit          chkFirst;
    logic [31:0] expFirst;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  xbox_xlr_mvmul #(
    .NUM_MEMS(NM),
    .LOG2_LINES_PER_MEM(AW),
    .ACC_W(32),
    .GO_REG(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .xlr_mem_addr(addr),
    .xlr_mem_wdata(wdata),
    .xlr_mem_be(be),
    .xlr_mem_rd(rd),
    .xlr_mem_wr(wr),
    .xlr_mem_rdata(rdata),
    .host_regs(hostRegs),
    .host_regs_valid_pulse(hostPulse),
    .host_regs_data_out(dataOut),
    .host_regs_valid_out(validOut)
  );

  // Synchronous TCM model: read data appears the cycle after rd, writes honour byte enables.
  always @(posedge clk) begin
    if (!mem2Init) begin
      for (int l = 0; l < LINES; l++) mem2[l] <= {8{32'hA5A5_0000 | 32'(l)}};
      mem2Init <= 1'b1;
    end
    if (rd[0]) begin rdata[255:0]   <= mem0[addr[7:0]];   rdCnt[0] <= rdCnt[0] + 1; end
    if (rd[1]) begin rdata[511:256] <= mem1[addr[15:8]];  rdCnt[1] <= rdCnt[1] + 1; end
    if (rd[2]) begin rdata[767:512] <= mem2[addr[23:16]]; rdCnt[2] <= rdCnt[2] + 1; end
    if (wr[0]) wrCnt[0] <= wrCnt[0] + 1;
    if (wr[1]) wrCnt[1] <= wrCnt[1] + 1;
    if (wr[2]) begin
      wrCnt[2] <= wrCnt[2] + 1;
      for (int j = 0; j < 32; j++)
        if (be[64+j]) mem2[addr[23:16]][8*j +: 8] <= wdata[512 + 8*j +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit mode, input int lenL, input int rowsR);
    hostRegs[64 +: 32]  = 32'(lenL);
    hostRegs[96 +: 32]  = 32'(rowsR);
    hostRegs[128 +: 32] = {31'b0, mode};
    hostRegs[256 +: 32] = 32'd1;
    hostPulse = 32'h0000_011C;
    @(negedge clk);
    hostPulse = 32'h0;
  endtask

  function automatic logic [255:0] makeLine(input bit mode, input logic [15:0] v);
    logic [255:0] line;
    for (int i = 0; i < 16; i++) line[16*i +: 16] = mode ? v : {v[7:0], v[7:0]};
    return line;
  endfunction

  task automatic fillMems(input int pat, input bit mode, input int lenL,
                          input logic [15:0] aval, input logic [15:0] bval);
    for (int n = 0; n < LINES; n++) begin
      if (pat == 2) begin
        mem0[n] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mem1[n] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        mem0[n] = makeLine(mode, (pat == 1) ? 16'(n / lenL + 1) : aval);
        mem1[n] = makeLine(mode, bval);
      end
    end
  endtask

  // Reference: row r result is the sum over lines k of the signed lane-wise dot product of A[r*L+k] and B[k].
  function automatic logic [31:0] refRow(input bit mode, input int lenL, input int r);
    longint s = 0;
    logic [255:0] al, bl;
    int x, y;
    for (int k = 0; k < lenL; k++) begin
      al = mem0[r*lenL + k];
      bl = mem1[k];
      if (mode) begin
        for (int i = 0; i < 16; i++) begin
          x = int'($signed(al[16*i +: 16]));
          y = int'($signed(bl[16*i +: 16]));
          s += longint'(x) * longint'(y);
        end
      end else begin
        for (int i = 0; i < 32; i++) begin
          x = int'($signed(al[8*i +: 8]));
          y = int'($signed(bl[8*i +: 8]));
          s += longint'(x) * longint'(y);
        end
      end
    end
    return s[31:0];
  endfunction

  task automatic startRun(input string name, input bit mode, input int lenL, input int rowsR);
    for (int m = 0; m < 3; m++) begin rdBase[m] = rdCnt[m]; wrBase[m] = wrCnt[m]; end
    for (int l = 0; l < LINES; l++) exp2[l] = mem2[l];
    applyStimulus(mode, lenL, rowsR);
    checkOutput({name, "_busy"}, dataOut[31:0], 32'h2);
  endtask

  task automatic finishRun(input string name, input bit mode, input int lenL, input int rowsR,
                           input bit chkFirst, input logic [31:0] expFirst);
    int bad = 0;
    for (int c = 0; c < rowsR*(lenL+2) + 20 && !dataOut[0]; c++) @(negedge clk);
    checkOutput({name, "_status"}, dataOut[31:0], 32'h1);
    checkOutput({name, "_cycles"}, dataOut[63:32], 32'(rowsR*(lenL+2)));
    checkOutput({name, "_rd0"}, 32'(rdCnt[0] - rdBase[0]), 32'(rowsR*lenL));
    checkOutput({name, "_rd1"}, 32'(rdCnt[1] - rdBase[1]), 32'(rowsR*lenL));
    checkOutput({name, "_wr2"}, 32'(wrCnt[2] - wrBase[2]), 32'(rowsR));
    checkOutput({name, "_illegal"}, 32'(rdCnt[2] - rdBase[2] + wrCnt[0] - wrBase[0] + wrCnt[1] - wrBase[1]), 32'd0);
    for (int r = 0; r < rowsR; r++) exp2[r >> 3][32*(r % 8) +: 32] = refRow(mode, lenL, r);
    for (int l = 0; l < LINES; l++) begin
      if (mem2[l] !== exp2[l]) begin
        if (bad == 0) $display("[TB] %s: first differing MEM2 line %0d got %h expected %h", name, l, mem2[l], exp2[l]);
        bad++;
      end
    end
    checkOutput({name, "_mem2_lines_bad"}, 32'(bad), 32'd0);
    if (chkFirst) checkOutput({name, "_row0"}, mem2[0][31:0], expFirst);
  endtask

  task automatic runError(input string name, input bit mode, input int lenL, input int rowsR);
    for (int m = 0; m < 3; m++) begin rdBase[m] = rdCnt[m]; wrBase[m] = wrCnt[m]; end
    applyStimulus(mode, lenL, rowsR);
    checkOutput({name, "_status"}, dataOut[31:0], 32'h5);
    repeat (4) @(negedge clk);
    checkOutput({name, "_strobes"}, 32'(rdCnt[0] - rdBase[0] + rdCnt[1] - rdBase[1] + rdCnt[2] - rdBase[2] +
                                        wrCnt[0] - wrBase[0] + wrCnt[1] - wrBase[1] + wrCnt[2] - wrBase[2]), 32'd0);
    checkOutput({name, "_cycles"}, dataOut[63:32], 32'd0);
    checkOutput({name, "_hold"}, dataOut[31:0], 32'h5);
  endtask

  function automatic logic [31:0] strobeBits();
    return {27'b0, |addr, |wdata, |be, |rd, |wr};
  endfunction

  initial begin
    vecs[0]  = '{"int8_basic",   1'b0, 1,   1,   0, 16'h0001, 16'h0002, 1'b0, 1'b1, 32'd64};
    vecs[1]  = '{"int16_rows",   1'b1, 2,   3,   1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 32'hFFFF_FFE0};
    vecs[2]  = '{"int8_r9",      1'b0, 1,   9,   0, 16'h007F, 16'h007F, 1'b0, 1'b1, 32'd516128};
    vecs[3]  = '{"int16_wrap",   1'b1, 256, 1,   0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 32'hF000_1000};
    vecs[4]  = '{"int8_16x16",   1'b0, 16,  16,  2, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{"int16_rand",   1'b1, 5,   7,   2, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{"int8_r256",    1'b0, 1,   256, 2, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'd0};
    vecs[7]  = '{"err_r0",       1'b0, 1,   0,   0, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{"err_rl257",    1'b0, 1,   257, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'd0};
    vecs[9]  = '{"err_l0",       1'b0, 0,   4,   0, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'd0};
    vecs[10] = '{"err_l257",     1'b1, 257, 1,   0, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'd0};

    rst = 1'b1;
    hostRegs = '0;
    hostPulse = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_status", dataOut[31:0], 32'h0);
    checkOutput("reset_cycles", dataOut[63:32], 32'h0);
    checkOutput("reset_valid_out", validOut, 32'h3);
    checkOutput("reset_strobes", strobeBits(), 32'h0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].expErr) begin
        runError(vecs[v].name, vecs[v].mode, vecs[v].lenL, vecs[v].rowsR);
      end else begin
        fillMems(vecs[v].pat, vecs[v].mode, vecs[v].lenL, vecs[v].aval, vecs[v].bval);
        startRun(vecs[v].name, vecs[v].mode, vecs[v].lenL, vecs[v].rowsR);
        finishRun(vecs[v].name, vecs[v].mode, vecs[v].lenL, vecs[v].rowsR, vecs[v].chkFirst, vecs[v].expFirst);
      end
    end

    for (int n = 0; n < 4; n++) begin
      bit rm;
      int rl, rr;
      rm = 1'($urandom_range(0, 1));
      rl = int'($urandom_range(1, 12));
      rr = int'($urandom_range(1, 30));
      if (rr * rl > LINES) rr = LINES / rl;
      fillMems(2, rm, rl, 16'h0, 16'h0);
      startRun("random", rm, rl, rr);
      finishRun("random", rm, rl, rr, 1'b0, 32'd0);
    end

    // A second go and a CSR rewrite mid-run must not disturb the run in flight.
    fillMems(2, 1'b0, 3, 16'h0, 16'h0);
    startRun("go_busy", 1'b0, 3, 5);
    repeat (3) @(negedge clk);
    hostRegs[64 +: 32] = 32'd7;
    hostPulse = 32'h4;
    @(negedge clk);
    hostPulse = 32'h0;
    applyStimulus(1'b1, 1, 1);
    finishRun("go_busy", 1'b0, 3, 5, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("done_hold_status", dataOut[31:0], 32'h1);
    checkOutput("done_hold_cycles", dataOut[63:32], 32'd25);

    // Reset while row 1 is being read, then a fresh run.
    fillMems(2, 1'b1, 2, 16'h0, 16'h0);
    startRun("reset_mid", 1'b1, 2, 3);
    repeat (4) @(negedge clk);
    checkOutput("reset_mid_active", 32'(rd[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_mid_strobes", strobeBits(), 32'h0);
    checkOutput("reset_mid_status", dataOut[31:0], 32'h0);
    checkOutput("reset_mid_cycles", dataOut[63:32], 32'h0);
    startRun("after_reset", 1'b1, 2, 3);
    finishRun("after_reset", 1'b1, 2, 3, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
